// File: rtl/segdisp_scan.sv
// segdisp_scan: CPU-mapped, time-multiplexed 7-segment controller that scans NDIG digits with per-slot dead-time.
// Latency: bus writes commit at the posedge; seg/dig reflect them one edge later. Read data is on dout the cycle after the access.
// Backpressure: none. The bus accepts one access per cycle and seg/dig are free-running outputs.
//
// Ports:
//   clk      system clock (single domain)
//   rst      synchronous reset, active-high
//   cs       chip select; read=1 reads, read=0 writes
//   address  register index: 0..NDIG-1 DIGITn, NDIG CTRL, NDIG+1 BLANK, others unmapped (read 8'hFF)
//   din      write data
//   dout     registered read data; holds between reads
//   seg      {dp,g,f,e,d,c,b,a}; polarity per SEG_ACT_LOW
//   dig      one-hot digit enable, bit0 = leftmost; polarity per DIG_ACT_LOW
//
// Build option: define SEGDISP_PWM_EN to add the brightness PWM driven by CTRL[7:4].
// Without it, CTRL[7:4] reads 4'hF and digits are lit for the whole active phase.
module segdisp_scan #(
    parameter int NDIG        = 4,
    parameter int ADDR_W      = 4,
    parameter int DIV         = 2048,
    parameter int DEAD        = 4,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic [7:0]        seg,
    output logic [NDIG-1:0]   dig
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [ADDR_W-1:0] CTRL_ADDR  = ADDR_W'(NDIG);
    localparam logic [ADDR_W-1:0] BLANK_ADDR = ADDR_W'(NDIG + 1);
    localparam logic [PW-1:0]     PRESC_MAX  = PW'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX    = IDX_W'(NDIG - 1);

    // Segment levels driven while nothing is shown.
    localparam logic [7:0]      SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NDIG-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [7:0]      digit_q [NDIG];
    logic            en_q;
    logic            raw_q;
    logic [NDIG-1:0] blank_q;
    logic [3:0]      bri_rd;

    logic wr_acc;
    logic rd_acc;

    assign wr_acc = cs && !read;
    assign rd_acc = cs && read;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NDIG; i++) begin
                digit_q[i] <= 8'h00;
            end
            en_q    <= 1'b1;
            raw_q   <= 1'b0;
            blank_q <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NDIG; i++) begin
                if (address == ADDR_W'(i)) begin
                    digit_q[i] <= din;
                end
            end
            if (address == CTRL_ADDR) begin
                en_q  <= din[0];
                raw_q <= din[1];
            end
            if (address == BLANK_ADDR) begin
                blank_q <= din[NDIG-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional brightness PWM
    // ------------------------------------------------------------------
    logic pwm_on;

`ifdef SEGDISP_PWM_EN
    logic [3:0] bri_q;
    logic [3:0] pwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bri_q <= 4'hF;
        end else if (wr_acc && (address == CTRL_ADDR)) begin
            bri_q <= din[7:4];
        end
    end

    // Free-running 16-step duty counter, independent of the scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= 4'h0;
        end else begin
            pwm_q <= pwm_q + 4'h1;
        end
    end

    // Brightness 15 keeps the digit on for all 16 steps, 0 for one step.
    assign pwm_on = (pwm_q <= bri_q);
    assign bri_rd = bri_q;
`else
    assign pwm_on = 1'b1;
    assign bri_rd = 4'hF;
`endif

    // ------------------------------------------------------------------
    // Bus read path
    // ------------------------------------------------------------------
    logic [7:0] rd_dat;

    always_comb begin
        rd_dat = 8'hFF;
        for (int i = 0; i < NDIG; i++) begin
            if (address == ADDR_W'(i)) begin
                rd_dat = digit_q[i];
            end
        end
        if (address == CTRL_ADDR) begin
            rd_dat = {bri_rd, 2'b00, raw_q, en_q};
        end
        if (address == BLANK_ADDR) begin
            // Unimplemented BLANK bits read as zero.
            rd_dat = 8'(blank_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 8'hFF;
        end else if (rd_acc) begin
            dout <= rd_dat;
        end
    end

    // ------------------------------------------------------------------
    // Scan timing: prescaler gives the position within a slot, idx the slot.
    // Both sit at zero while disabled so re-enabling always starts at digit 0
    // with a full dead-time.
    // ------------------------------------------------------------------
    logic [PW-1:0]    presc_q;
    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (rst || !en_q) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            idx_q   <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    logic in_dead;

    generate
        if (DEAD == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = (presc_q < PW'(DEAD));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Segment generation
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex7(input logic [3:0] n);
        // {g,f,e,d,c,b,a}, active-high
        hex7 = 7'h00;
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            4'hF: hex7 = 7'h71;
            default: hex7 = 7'h00;
        endcase
    endfunction

    logic [7:0]      cur_dat;
    logic            cur_blank;
    logic            lit;
    logic [7:0]      seg_nxt;
    logic [NDIG-1:0] dig_nxt;

    always_comb begin
        cur_dat   = 8'h00;
        cur_blank = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_dat   = digit_q[i];
                cur_blank = blank_q[i];
            end
        end
    end

    assign lit = en_q && !in_dead && !cur_blank && pwm_on;

    // Segments are forced dark together with the digit enables so no ghost
    // pattern is driven while every digit is off.
    always_comb begin
        seg_nxt = 8'h00;
        dig_nxt = '0;
        if (lit) begin
            seg_nxt = raw_q ? cur_dat : {cur_dat[7], hex7(cur_dat[3:0])};
            for (int i = 0; i < NDIG; i++) begin
                dig_nxt[i] = (idx_q == IDX_W'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_OFF;
            dig <= DIG_OFF;
        end else begin
            seg <= (SEG_ACT_LOW != 0) ? ~seg_nxt : seg_nxt;
            dig <= (DIG_ACT_LOW != 0) ? ~dig_nxt : dig_nxt;
        end
    end

endmodule
